// File: rtl/register_file_sb.sv
// Register bank with one write port, two registered write-first read ports, a per-register
// busy scoreboard, and a sweep engine that zeroes the bank one entry per cycle.
module register_file_sb #(
  parameter int DATA_W   = 26,
  parameter int NUM_REGS = 13,
  parameter int ADDR_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_RF,
  input  logic [ADDR_W-1:0]          A3,
  input  logic [DATA_W-1:0]          WD3,
  input  logic [ADDR_W-1:0]          A1,
  input  logic [ADDR_W-1:0]          A2,
  output logic [DATA_W-1:0]          RD1,
  output logic [DATA_W-1:0]          RD2,
  output logic                       busy1,
  output logic                       busy2,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_dst,
  input  logic                       clr_req,
  output logic                       ready,
  output logic [DATA_W*NUM_REGS-1:0] bank_flat
);

  // state   | meaning
  // S_IDLE  | normal operation, writes/issues accepted
  // S_CLEAR | zeroing entry ptr_q each cycle, writes/issues ignored
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam int                PTR_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NR_A     = (ADDR_W + 1)'(NUM_REGS);

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               ready_q;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic                b1_q, b1_d, b2_q, b2_d;

  logic a1_ok, a2_ok, a3_ok, dst_ok;

  assign a1_ok  = ({1'b0, A1} < NR_A);
  assign a2_ok  = ({1'b0, A2} < NR_A);
  assign a3_ok  = ({1'b0, A3} < NR_A);
  assign dst_ok = ({1'b0, iss_dst} < NR_A);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Post-edge bank contents; the read ports look at these so reads are write-first.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (state_q == S_CLEAR) begin
      mem_d[ptr_q]  = '0;
      busy_d[ptr_q] = 1'b0;
    end else if (ready_q) begin
      if (we_RF && a3_ok) begin
        mem_d[A3[PTR_W-1:0]]  = WD3;
        busy_d[A3[PTR_W-1:0]] = 1'b0;
      end
      if (iss_en && dst_ok) begin
        busy_d[iss_dst[PTR_W-1:0]] = 1'b1;
      end
    end
    rd1_d = a1_ok ? mem_d[A1[PTR_W-1:0]]  : '0;
    b1_d  = a1_ok ? busy_d[A1[PTR_W-1:0]] : 1'b0;
    rd2_d = a2_ok ? mem_d[A2[PTR_W-1:0]]  : '0;
    b2_d  = a2_ok ? busy_d[A2[PTR_W-1:0]] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      b1_q   <= 1'b0;
      b2_q   <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      b1_q   <= b1_d;
      b2_q   <= b2_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bank_flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

  assign RD1   = rd1_q;
  assign RD2   = rd2_q;
  assign busy1 = b1_q;
  assign busy2 = b2_q;
  assign ready = ready_q;

endmodule
